// File: rtl/wb_select_stage_if.sv
// ---------------------------------------------------------------------------
// wb_select_stage_if
//   Bundles the upstream entry fields, the valid/ready handshakes and the
//   writeback outputs of the writeback-select stage.
//
//   Modports
//     master : environment view (drives the entry and out_ready, observes the
//              writeback outputs)
//     slave  : stage view (consumes the entry, drives the writeback outputs)
//
//   Signals
//     in_valid / in_ready      upstream handshake
//     flush                    squash of held and incoming entry
//     reg_write, dst_sel       destination control (00 rt, 01 rd, 10 link, 11 none)
//     instr_rt, instr_rd       register fields of the instruction
//     data_sel, src_data       data source index and packed data sources
//     ld_size, ld_signed,      sub-word load control
//     byte_off
//     out_valid / out_ready    downstream handshake
//     wb_we, wb_addr, wb_data  register-file write port
//     retire_cnt               count of retired entries
// ---------------------------------------------------------------------------
interface wb_select_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 4
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic                   reg_write;
    logic [1:0]             dst_sel;
    logic [REG_AW-1:0]      instr_rt;
    logic [REG_AW-1:0]      instr_rd;
    logic [SEL_W-1:0]       data_sel;
    logic [NSRC*DATA_W-1:0] src_data;
    logic [1:0]             ld_size;
    logic                   ld_signed;
    logic [1:0]             byte_off;
    logic                   out_valid;
    logic                   out_ready;
    logic                   wb_we;
    logic [REG_AW-1:0]      wb_addr;
    logic [DATA_W-1:0]      wb_data;
    logic [31:0]            retire_cnt;

    modport master (
        output in_valid, flush, reg_write, dst_sel, instr_rt, instr_rd,
               data_sel, src_data, ld_size, ld_signed, byte_off, out_ready,
        input  in_ready, out_valid, wb_we, wb_addr, wb_data, retire_cnt
    );

    modport slave (
        input  in_valid, flush, reg_write, dst_sel, instr_rt, instr_rd,
               data_sel, src_data, ld_size, ld_signed, byte_off, out_ready,
        output in_ready, out_valid, wb_we, wb_addr, wb_data, retire_cnt
    );
endinterface

// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//   Registered writeback-select stage between MEM and the register file.
//   Resolves the destination register (rt / rd / link register / none) and the
//   writeback data (one of NSRC packed sources) into a single pipeline register
//   guarded by a valid/ready handshake, with flush and a retire counter.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    wb_select_stage_if.slave (entry in, writeback out, handshakes)
//
//   Configuration macro
//     LOAD_EXT_EN  when defined, the memory-load source (MEM_IDX) is
//                  lane-selected by byte_off and sign/zero extended according
//                  to ld_size / ld_signed before it is registered. When
//                  undefined the memory word passes through unchanged and the
//                  load-control fields are ignored.
// ---------------------------------------------------------------------------
module wb_select_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NSRC     = 4,
    parameter int MEM_IDX  = 1,
    parameter int LINK_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_select_stage_if.slave       bus
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

`ifdef LOAD_EXT_EN
    // Little-endian lane select and extension of a loaded word.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        off
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[8*int'(off) +: 8];
        half_v = word[16*int'(off[1]) +: 16];
        case (size)
            2'b01:   load_extend = {{(DATA_W-16){sgn & half_v[15]}}, half_v};
            2'b10:   load_extend = {{(DATA_W-8){sgn & byte_v[7]}}, byte_v};
            default: load_extend = word;
        endcase
    endfunction
`else
    // The load-control fields have no effect in this build.
    logic unused_load_ctl_s;
    assign unused_load_ctl_s = ^{bus.ld_size, bus.ld_signed, bus.byte_off};
`endif

    // Pipeline register
    logic              out_valid_r;
    logic              wb_we_r;
    logic [REG_AW-1:0] wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [31:0]       retire_cnt_r;

    // Next-state and decode signals
    logic              in_ready_s;
    logic              capture_s;
    logic              retire_s;
    logic [REG_AW-1:0] dst_addr_s;
    logic              dst_we_s;
    logic [DATA_W-1:0] src_mux_s;
    logic [DATA_W-1:0] wb_data_in_s;
    logic              out_valid_s;
    logic              wb_we_s;
    logic [REG_AW-1:0] wb_addr_s;
    logic [DATA_W-1:0] wb_data_s;

    // Handshake qualifiers; flush blocks capture but not the downstream retire.
    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign capture_s  = bus.in_valid && in_ready_s && !bus.flush;
    assign retire_s   = out_valid_r && bus.out_ready;

    // Destination register and write-enable decode; writes to $0 are dropped.
    always_comb begin
        dst_addr_s = {REG_AW{1'b0}};
        case (bus.dst_sel)
            2'b00:   dst_addr_s = bus.instr_rt;
            2'b01:   dst_addr_s = bus.instr_rd;
            2'b10:   dst_addr_s = REG_AW'(LINK_REG);
            default: dst_addr_s = {REG_AW{1'b0}};
        endcase
        dst_we_s = bus.reg_write && (bus.dst_sel != 2'b11)
                   && (dst_addr_s != {REG_AW{1'b0}});
    end

    // Data source mux; an index with no matching source yields zero.
    always_comb begin
        src_mux_s = {DATA_W{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (bus.data_sel == SEL_W'(i)) begin
                src_mux_s = bus.src_data[i*DATA_W +: DATA_W];
            end else begin
                src_mux_s = src_mux_s;
            end
        end
    end

    // Optional load formatting applied only to the memory source.
    always_comb begin
        wb_data_in_s = src_mux_s;
`ifdef LOAD_EXT_EN
        if (bus.data_sel == SEL_W'(MEM_IDX)) begin
            wb_data_in_s = load_extend(src_mux_s, bus.ld_size, bus.ld_signed,
                                       bus.byte_off);
        end else begin
            wb_data_in_s = src_mux_s;
        end
`endif
    end

    // Pipeline register next state: load, empty (retire or flush), or hold.
    always_comb begin
        out_valid_s = out_valid_r;
        wb_we_s     = wb_we_r;
        wb_addr_s   = wb_addr_r;
        wb_data_s   = wb_data_r;
        if (capture_s) begin
            out_valid_s = 1'b1;
            wb_we_s     = dst_we_s;
            wb_addr_s   = dst_addr_s;
            wb_data_s   = wb_data_in_s;
        end else if (retire_s || bus.flush) begin
            // Write enable follows valid down so a stale entry never writes.
            out_valid_s = 1'b0;
            wb_we_s     = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
            wb_we_s     = wb_we_r;
        end
    end

    // Pipeline register and retire counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            wb_we_r      <= 1'b0;
            wb_addr_r    <= {REG_AW{1'b0}};
            wb_data_r    <= {DATA_W{1'b0}};
            retire_cnt_r <= 32'd0;
        end else begin
            out_valid_r <= out_valid_s;
            wb_we_r     <= wb_we_s;
            wb_addr_r   <= wb_addr_s;
            wb_data_r   <= wb_data_s;
            if (retire_s) begin
                retire_cnt_r <= retire_cnt_r + 32'd1;
            end else begin
                retire_cnt_r <= retire_cnt_r;
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.wb_we      = wb_we_r;
    assign bus.wb_addr    = wb_addr_r;
    assign bus.wb_data    = wb_data_r;
    assign bus.retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_select_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_select_stage
//   Directed bench for wb_select_stage. Inputs change 1 ns after the rising
//   edge and outputs are sampled at that same point, i.e. well away from the
//   edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_select_stage;
    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    wb_select_stage_if #(.DATA_W(32), .REG_AW(5), .NSRC(4)) wbif ();

    wb_select_stage #(
        .DATA_W(32), .REG_AW(5), .NSRC(4), .MEM_IDX(1), .LINK_REG(31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3);
        wbif.src_data = {s3, s2, s1, s0};
    endtask

    task automatic set_entry(input logic rw, input logic [1:0] ds,
                             input logic [4:0] rt, input logic [4:0] rd,
                             input logic [1:0] dsel);
        wbif.in_valid  = 1'b1;
        wbif.reg_write = rw;
        wbif.dst_sel   = ds;
        wbif.instr_rt  = rt;
        wbif.instr_rd  = rd;
        wbif.data_sel  = dsel;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        wbif.in_valid  = 1'b0;
        wbif.flush     = 1'b0;
        wbif.reg_write = 1'b0;
        wbif.dst_sel   = 2'b00;
        wbif.instr_rt  = 5'd0;
        wbif.instr_rd  = 5'd0;
        wbif.data_sel  = 2'd0;
        wbif.ld_size   = 2'b00;
        wbif.ld_signed = 1'b0;
        wbif.byte_off  = 2'b00;
        wbif.out_ready = 1'b1;
        set_src(32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        vec_cnt++;
        if ({wbif.out_valid, wbif.wb_we, wbif.wb_addr, wbif.wb_data, wbif.retire_cnt} !== 71'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got v=%0b we=%0b a=%0d d=%h c=%0d, want all 0",
                     wbif.out_valid, wbif.wb_we, wbif.wb_addr, wbif.wb_data, wbif.retire_cnt);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu();
        set_src(32'h0000_1234, 32'h0, 32'h0, 32'h0);
        set_entry(1'b1, 2'b00, 5'd8, 5'd3, 2'd0);
        wbif.out_ready = 1'b1;
        step();
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if ({wbif.out_valid, wbif.wb_we} !== 2'b11) begin
            err_cnt++;
            $display("FAIL alu_valid_we: got %b, want 11", {wbif.out_valid, wbif.wb_we});
        end
        vec_cnt++;
        if (wbif.wb_addr !== 5'd8 || wbif.wb_data !== 32'h0000_1234) begin
            err_cnt++;
            $display("FAIL alu_addr_data: got %0d/%h, want 8/00001234", wbif.wb_addr, wbif.wb_data);
        end
        step();
        vec_cnt++;
        if (wbif.retire_cnt !== 32'd1 || wbif.out_valid !== 1'b0 || wbif.wb_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_retire: got cnt=%0d v=%0b we=%0b, want 1/0/0",
                     wbif.retire_cnt, wbif.out_valid, wbif.wb_we);
        end
    endtask

    task automatic test_link_and_zero();
        set_src(32'h0000_0055, 32'h0, 32'h0040_0008, 32'hCAFE_F00D);
        set_entry(1'b1, 2'b10, 5'd7, 5'd9, 2'd2);
        step();
        vec_cnt++;
        if (wbif.wb_addr !== 5'd31 || wbif.wb_data !== 32'h0040_0008 || wbif.wb_we !== 1'b1) begin
            err_cnt++;
            $display("FAIL link: got a=%0d d=%h we=%0b, want 31/00400008/1",
                     wbif.wb_addr, wbif.wb_data, wbif.wb_we);
        end
        set_entry(1'b1, 2'b01, 5'd7, 5'd0, 2'd3);
        step();
        vec_cnt++;
        if (wbif.wb_we !== 1'b0 || wbif.wb_addr !== 5'd0 || wbif.wb_data !== 32'hCAFE_F00D
            || wbif.out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL rd_zero: got we=%0b a=%0d d=%h v=%0b, want 0/0/cafef00d/1",
                     wbif.wb_we, wbif.wb_addr, wbif.wb_data, wbif.out_valid);
        end
        vec_cnt++;
        if (wbif.retire_cnt !== 32'd2) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d, want 2", wbif.retire_cnt);
        end
        set_entry(1'b1, 2'b11, 5'd5, 5'd6, 2'd0);
        step();
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if (wbif.wb_we !== 1'b0 || wbif.wb_addr !== 5'd0 || wbif.wb_data !== 32'h0000_0055) begin
            err_cnt++;
            $display("FAIL no_write_sel: got we=%0b a=%0d d=%h, want 0/0/00000055",
                     wbif.wb_we, wbif.wb_addr, wbif.wb_data);
        end
        step();
        vec_cnt++;
        if (wbif.retire_cnt !== 32'd4 || wbif.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL link_drain: got cnt=%0d v=%0b, want 4/0", wbif.retire_cnt, wbif.out_valid);
        end
    endtask

    task automatic test_back_to_back_hold();
        set_src(32'h1111_1111, 32'h0, 32'h0, 32'h0);
        set_entry(1'b1, 2'b01, 5'd1, 5'd10, 2'd0);
        wbif.out_ready = 1'b1;
        step();
        wbif.out_ready = 1'b0;
        set_src(32'h2222_2222, 32'h0, 32'h0, 32'h0);
        set_entry(1'b1, 2'b01, 5'd1, 5'd12, 2'd0);
        #1;
        vec_cnt++;
        if (wbif.in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_in_ready: got %0b, want 0", wbif.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (wbif.out_valid !== 1'b1 || wbif.wb_addr !== 5'd10 || wbif.wb_data !== 32'h1111_1111
                || wbif.in_ready !== 1'b0 || wbif.retire_cnt !== 32'd4) begin
                err_cnt++;
                $display("FAIL hold_stable[%0d]: got v=%0b a=%0d d=%h rdy=%0b c=%0d, want 1/10/11111111/0/4",
                         i, wbif.out_valid, wbif.wb_addr, wbif.wb_data, wbif.in_ready, wbif.retire_cnt);
            end
        end
        wbif.out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (wbif.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL release_in_ready: got %0b, want 1", wbif.in_ready);
        end
        step();
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if (wbif.out_valid !== 1'b1 || wbif.wb_addr !== 5'd12 || wbif.wb_data !== 32'h2222_2222
            || wbif.retire_cnt !== 32'd5) begin
            err_cnt++;
            $display("FAIL retire_and_load: got v=%0b a=%0d d=%h c=%0d, want 1/12/22222222/5",
                     wbif.out_valid, wbif.wb_addr, wbif.wb_data, wbif.retire_cnt);
        end
        step();
        vec_cnt++;
        if (wbif.retire_cnt !== 32'd6 || wbif.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_drain: got cnt=%0d v=%0b, want 6/0", wbif.retire_cnt, wbif.out_valid);
        end
    endtask

    task automatic test_flush_wrap();
        set_src(32'h3333_3333, 32'h0, 32'h0, 32'h0);
        set_entry(1'b1, 2'b00, 5'd3, 5'd0, 2'd0);
        wbif.flush = 1'b1;
        step();
        vec_cnt++;
        if (wbif.out_valid !== 1'b0 || wbif.wb_we !== 1'b0 || wbif.retire_cnt !== 32'd6) begin
            err_cnt++;
            $display("FAIL flush_incoming: got v=%0b we=%0b c=%0d, want 0/0/6",
                     wbif.out_valid, wbif.wb_we, wbif.retire_cnt);
        end
        wbif.flush = 1'b0;
        step();
        wbif.flush = 1'b1;
        set_entry(1'b1, 2'b00, 5'd4, 5'd0, 2'd0);
        step();
        wbif.flush = 1'b0;
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if (wbif.out_valid !== 1'b0 || wbif.wb_we !== 1'b0 || wbif.retire_cnt !== 32'd7) begin
            err_cnt++;
            $display("FAIL flush_with_retire: got v=%0b we=%0b c=%0d, want 0/0/7",
                     wbif.out_valid, wbif.wb_we, wbif.retire_cnt);
        end
        set_entry(1'b1, 2'b00, 5'd5, 5'd0, 2'd0);
        step();
        wbif.in_valid  = 1'b0;
        wbif.out_ready = 1'b0;
        wbif.flush     = 1'b1;
        step();
        wbif.flush = 1'b0;
        vec_cnt++;
        if (wbif.out_valid !== 1'b0 || wbif.retire_cnt !== 32'd7) begin
            err_cnt++;
            $display("FAIL flush_held: got v=%0b c=%0d, want 0/7", wbif.out_valid, wbif.retire_cnt);
        end
        wbif.out_ready = 1'b1;
        set_entry(1'b1, 2'b00, 5'd6, 5'd0, 2'd0);
        step();
        wbif.in_valid  = 1'b0;
        wbif.out_ready = 1'b0;
        force dut.retire_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_r;
        #1;
        vec_cnt++;
        if (wbif.retire_cnt !== 32'hFFFF_FFFF || wbif.out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap_preset: got c=%h v=%0b, want ffffffff/1", wbif.retire_cnt, wbif.out_valid);
        end
        wbif.out_ready = 1'b1;
        step();
        vec_cnt++;
        if (wbif.retire_cnt !== 32'd0) begin
            err_cnt++;
            $display("FAIL wrap: got %h, want 00000000", wbif.retire_cnt);
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
        logic [1:0]  off [6] = '{2'd2,  2'd2,  2'd3,  2'd2,  2'd0,  2'd1};
        logic        sgn [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
`ifdef LOAD_EXT_EN
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'h0000_80FF, 32'hFFFF_FF80,
                                 32'hFFFF_80FF, 32'h0000_0001, 32'h80FF_7F01};
`else
        logic [31:0] exp [6] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                                 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
        set_src(32'hDEAD_BEEF, 32'h80FF_7F01, 32'h0, 32'h0);
        wbif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_entry(1'b1, 2'b00, 5'd4, 5'd0, 2'd1);
            wbif.ld_size   = sz[i];
            wbif.byte_off  = off[i];
            wbif.ld_signed = sgn[i];
            step();
            vec_cnt++;
            if (wbif.wb_data !== exp[i]) begin
                err_cnt++;
                $display("FAIL load_ext[%0d]: got %h, want %h", i, wbif.wb_data, exp[i]);
            end
        end
        set_entry(1'b1, 2'b00, 5'd4, 5'd0, 2'd0);
        wbif.ld_size   = 2'b10;
        wbif.byte_off  = 2'd1;
        wbif.ld_signed = 1'b1;
        step();
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if (wbif.wb_data !== 32'hDEAD_BEEF) begin
            err_cnt++;
            $display("FAIL non_mem_raw: got %h, want deadbeef", wbif.wb_data);
        end
        wbif.ld_size   = 2'b00;
        wbif.byte_off  = 2'd0;
        wbif.ld_signed = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_hold();
        set_src(32'h4444_4444, 32'h0, 32'h0, 32'h0);
        set_entry(1'b1, 2'b00, 5'd9, 5'd0, 2'd0);
        wbif.out_ready = 1'b0;
        step();
        wbif.in_valid = 1'b0;
        vec_cnt++;
        if (wbif.out_valid !== 1'b1 || wbif.retire_cnt === 32'd0) begin
            err_cnt++;
            $display("FAIL pre_reset_hold: got v=%0b c=%0d, want 1/nonzero", wbif.out_valid, wbif.retire_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({wbif.out_valid, wbif.wb_we, wbif.wb_addr, wbif.wb_data, wbif.retire_cnt} !== 71'd0) begin
            err_cnt++;
            $display("FAIL async_reset: got v=%0b we=%0b a=%0d d=%h c=%0d, want all 0",
                     wbif.out_valid, wbif.wb_we, wbif.wb_addr, wbif.wb_data, wbif.retire_cnt);
        end
        step();
        reset          = 1'b0;
        wbif.out_ready = 1'b1;
        step();
        vec_cnt++;
        if (wbif.out_valid !== 1'b0 || wbif.retire_cnt !== 32'd0) begin
            err_cnt++;
            $display("FAIL post_reset: got v=%0b c=%0d, want 0/0", wbif.out_valid, wbif.retire_cnt);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_alu();
        test_link_and_zero();
        test_back_to_back_hold();
        test_flush_wrap();
        test_load_ext();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
